// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Registered, flow-controlled RISC-V immediate generator.
//               Decodes the RV32I/RV64I immediate formats (I, S, B, U, J,
//               shift amount and, optionally, CSR zimm). Each immediate is
//               sign-extended to XLEN. The block also classifies the format
//               and flags unrecognised opcodes. It is one pipeline stage
//               with valid/ready handshakes on both sides. A one-entry skid
//               buffer lets in_ready be driven straight from a flop.
//
// Ports       : clk          - clock, rising edge
//               rst          - asynchronous active-high reset
//               in_valid     - upstream has an instruction
//               in_ready     - block can accept (registered)
//               in_instr     - 32-bit instruction word
//               in_tag       - sideband tag (typically the PC)
//               out_valid    - output register holds a result
//               out_ready    - downstream accepts
//               out_imm      - extended immediate, XLEN bits
//               out_fmt      - 0=R 1=I 2=S 3=B 4=U 5=J 6=SHAMT 7=CSR
//               out_illegal  - opcode not recognised
//               out_tag      - tag of the instruction on the output
//
// Parameters  : XLEN  - datapath width, 32 or 64
//               TAG_W - tag width
//
// Options     : IMM_GEN_ZICSR_EN - when defined, CSR immediate forms
//                                  (SYSTEM funct3 5/6/7) produce the zimm
//                                  field with format code 7.
//
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    // ------------------------------------------------------------------
    // Opcodes and format codes
    // ------------------------------------------------------------------
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;

    localparam logic [2:0] c_FMT_R     = 3'd0;
    localparam logic [2:0] c_FMT_I     = 3'd1;
    localparam logic [2:0] c_FMT_S     = 3'd2;
    localparam logic [2:0] c_FMT_B     = 3'd3;
    localparam logic [2:0] c_FMT_U     = 3'd4;
    localparam logic [2:0] c_FMT_J     = 3'd5;
    localparam logic [2:0] c_FMT_SHAMT = 3'd6;
`ifdef IMM_GEN_ZICSR_EN
    localparam logic [2:0] c_FMT_CSR   = 3'd7;
`endif

    // ------------------------------------------------------------------
    // Field extraction and per-format immediates
    // ------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_shamt;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];

    // Casting a signed operand to XLEN bits replicates its MSB, so each
    // format is sign-extended from its own top bit.
    assign w_imm_i = XLEN'($signed(in_instr[31:20]));
    assign w_imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign w_imm_b = XLEN'($signed({in_instr[31], in_instr[7],
                                    in_instr[30:25], in_instr[11:8], 1'b0}));
    assign w_imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign w_imm_j = XLEN'($signed({in_instr[31], in_instr[19:12],
                                    in_instr[20], in_instr[30:21], 1'b0}));

    // RV64 shifts take a 6-bit shift amount; RV32 shifts take 5 bits.
    generate
        if (XLEN == 64) begin : g_shamt_rv64
            assign w_imm_shamt = XLEN'(in_instr[25:20]);
        end else begin : g_shamt_rv32
            assign w_imm_shamt = XLEN'(in_instr[24:20]);
        end
    endgenerate

`ifdef IMM_GEN_ZICSR_EN
    logic [XLEN-1:0] w_imm_zimm;
    logic            w_is_csr_imm;

    assign w_imm_zimm   = XLEN'(in_instr[19:15]);
    // csrrwi / csrrsi / csrrci use funct3 5, 6 and 7.
    assign w_is_csr_imm = w_funct3[2] && (w_funct3[1:0] != 2'b00);
`endif

    // ------------------------------------------------------------------
    // Combinational decode of the word currently offered on the input
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_dec_imm;
    logic [2:0]      w_dec_fmt;
    logic            w_dec_illegal;

    always_comb begin
        w_dec_imm     = '0;
        w_dec_fmt     = c_FMT_R;
        w_dec_illegal = 1'b0;
        case (w_opcode)
            c_OPC_OP: begin
                w_dec_imm = '0;
                w_dec_fmt = c_FMT_R;
            end
            c_OPC_OP_IMM: begin
                if (w_funct3 == 3'd1 || w_funct3 == 3'd5) begin
                    w_dec_imm = w_imm_shamt;
                    w_dec_fmt = c_FMT_SHAMT;
                end else begin
                    w_dec_imm = w_imm_i;
                    w_dec_fmt = c_FMT_I;
                end
            end
            c_OPC_LOAD, c_OPC_JALR: begin
                w_dec_imm = w_imm_i;
                w_dec_fmt = c_FMT_I;
            end
            c_OPC_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
                if (w_is_csr_imm) begin
                    w_dec_imm = w_imm_zimm;
                    w_dec_fmt = c_FMT_CSR;
                end else begin
                    w_dec_imm = w_imm_i;
                    w_dec_fmt = c_FMT_I;
                end
`else
                w_dec_imm = w_imm_i;
                w_dec_fmt = c_FMT_I;
`endif
            end
            c_OPC_STORE: begin
                w_dec_imm = w_imm_s;
                w_dec_fmt = c_FMT_S;
            end
            c_OPC_BRANCH: begin
                w_dec_imm = w_imm_b;
                w_dec_fmt = c_FMT_B;
            end
            c_OPC_LUI, c_OPC_AUIPC: begin
                w_dec_imm = w_imm_u;
                w_dec_fmt = c_FMT_U;
            end
            c_OPC_JAL: begin
                w_dec_imm = w_imm_j;
                w_dec_fmt = c_FMT_J;
            end
            default: begin
                w_dec_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline storage: output register plus one-entry skid register
    // ------------------------------------------------------------------
    logic             r_in_ready;
    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_imm;
    logic [2:0]       r_out_fmt;
    logic             r_out_illegal;
    logic [TAG_W-1:0] r_out_tag;

    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_imm;
    logic [2:0]       r_skid_fmt;
    logic             r_skid_illegal;
    logic [TAG_W-1:0] r_skid_tag;

    logic w_accept;
    logic w_drain;
    logic w_out_load_dec;
    logic w_out_load_skid;
    logic w_skid_load;
    logic w_out_valid_nxt;
    logic w_skid_valid_nxt;

    assign w_accept = in_valid && r_in_ready;
    assign w_drain  = r_out_valid && out_ready;

    // in_ready is the registered inverse of skid occupancy, so an accept
    // can only happen while the skid register is empty.
    always_comb begin
        w_out_load_dec   = 1'b0;
        w_out_load_skid  = 1'b0;
        w_skid_load      = 1'b0;
        w_out_valid_nxt  = r_out_valid;
        w_skid_valid_nxt = r_skid_valid;
        if (r_skid_valid) begin
            if (w_drain) begin
                // Refill the output from the skid entry; the output stays valid.
                w_out_load_skid  = 1'b1;
                w_skid_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            if (!r_out_valid || w_drain) begin
                w_out_load_dec  = 1'b1;
                w_out_valid_nxt = 1'b1;
            end else begin
                w_skid_load      = 1'b1;
                w_skid_valid_nxt = 1'b1;
            end
        end else if (w_drain) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            r_in_ready   <= !w_skid_valid_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
        end
    end

    // Output payload changes only on a load, so it stays stable under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_imm     <= '0;
            r_out_fmt     <= '0;
            r_out_illegal <= 1'b0;
            r_out_tag     <= '0;
        end else if (w_out_load_skid) begin
            r_out_imm     <= r_skid_imm;
            r_out_fmt     <= r_skid_fmt;
            r_out_illegal <= r_skid_illegal;
            r_out_tag     <= r_skid_tag;
        end else if (w_out_load_dec) begin
            r_out_imm     <= w_dec_imm;
            r_out_fmt     <= w_dec_fmt;
            r_out_illegal <= w_dec_illegal;
            r_out_tag     <= in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_imm     <= '0;
            r_skid_fmt     <= '0;
            r_skid_illegal <= 1'b0;
            r_skid_tag     <= '0;
        end else if (w_skid_load) begin
            r_skid_imm     <= w_dec_imm;
            r_skid_fmt     <= w_dec_fmt;
            r_skid_illegal <= w_dec_illegal;
            r_skid_tag     <= in_tag;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_imm     = r_out_imm;
    assign out_fmt     = r_out_fmt;
    assign out_illegal = r_out_illegal;
    assign out_tag     = r_out_tag;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Directed self-checking bench for imm_gen_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    localparam int XLEN  = 32;
    localparam int TAG_W = 32;
    localparam int NVEC  = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    imm_gen_pipe #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_illegal (out_illegal),
        .out_tag     (out_tag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [XLEN-1:0] imm,
                             input logic [2:0] fmt, input logic ill,
                             input logic [TAG_W-1:0] tg);
        check({name, ".valid"},   64'(out_valid),   64'd1);
        check({name, ".imm"},     64'(out_imm),     64'(imm));
        check({name, ".fmt"},     64'(out_fmt),     64'(fmt));
        check({name, ".illegal"}, 64'(out_illegal), 64'(ill));
        check({name, ".tag"},     64'(out_tag),     64'(tg));
    endtask

    logic [31:0]     v_instr [NVEC];
    logic [XLEN-1:0] v_imm   [NVEC];
    logic [2:0]      v_fmt   [NVEC];
    logic            v_ill   [NVEC];

    initial begin
        // Hand-decoded vectors
        v_instr[0]  = 32'hFFF00093; v_imm[0]  = sx(32'hFFFFFFFF); v_fmt[0]  = 3'd1; v_ill[0]  = 1'b0; // addi -1
        v_instr[1]  = 32'hFE112E23; v_imm[1]  = sx(32'hFFFFFFFC); v_fmt[1]  = 3'd2; v_ill[1]  = 1'b0; // sw -4
        v_instr[2]  = 32'hFE000CE3; v_imm[2]  = sx(32'hFFFFFFF8); v_fmt[2]  = 3'd3; v_ill[2]  = 1'b0; // beq -8
        v_instr[3]  = 32'h123452B7; v_imm[3]  = sx(32'h12345000); v_fmt[3]  = 3'd4; v_ill[3]  = 1'b0; // lui
        v_instr[4]  = 32'h001000EF; v_imm[4]  = sx(32'h00000800); v_fmt[4]  = 3'd5; v_ill[4]  = 1'b0; // jal 2048
        v_instr[5]  = 32'h00309093; v_imm[5]  = sx(32'h00000003); v_fmt[5]  = 3'd6; v_ill[5]  = 1'b0; // slli 3
`ifdef IMM_GEN_ZICSR_EN
        v_instr[6]  = 32'h300FD073; v_imm[6]  = sx(32'h0000001F); v_fmt[6]  = 3'd7; v_ill[6]  = 1'b0; // csrrwi zimm
`else
        v_instr[6]  = 32'h300FD073; v_imm[6]  = sx(32'h00000300); v_fmt[6]  = 3'd1; v_ill[6]  = 1'b0; // csrrwi as I
`endif
        v_instr[7]  = 32'h0000007F; v_imm[7]  = sx(32'h00000000); v_fmt[7]  = 3'd0; v_ill[7]  = 1'b1; // illegal
        v_instr[8]  = 32'h002081B3; v_imm[8]  = sx(32'h00000000); v_fmt[8]  = 3'd0; v_ill[8]  = 1'b0; // add (R)
        v_instr[9]  = 32'h80000017; v_imm[9]  = sx(32'h80000000); v_fmt[9]  = 3'd4; v_ill[9]  = 1'b0; // auipc neg
        v_instr[10] = 32'h4030D093; v_imm[10] = sx(32'h00000003); v_fmt[10] = 3'd6; v_ill[10] = 1'b0; // srai 3
        v_instr[11] = 32'h80002083; v_imm[11] = sx(32'hFFFFF800); v_fmt[11] = 3'd1; v_ill[11] = 1'b0; // lw -2048

        // ---------------- reset state ----------------
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        #12;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready",  64'(in_ready),  64'd0);
        check("rst.out_imm",   64'(out_imm),   64'd0);
        check("rst.out_fmt",   64'(out_fmt),   64'd0);
        check("rst.out_tag",   64'(out_tag),   64'd0);
        rst = 1'b0;
        #1;
        check("rst.in_ready_before_edge", 64'(in_ready), 64'd0);
        step();
        check("rst.in_ready_after_edge", 64'(in_ready), 64'd1);

        // ---------------- back-to-back stream ----------------
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            in_valid = 1'b1;
            in_instr = v_instr[i];
            in_tag   = TAG_W'(32'h100 + i);
            step();
            check_out($sformatf("vec%0d", i), v_imm[i], v_fmt[i], v_ill[i], TAG_W'(32'h100 + i));
            check($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream.drained", 64'(out_valid), 64'd0);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093; in_tag = 32'hA;
        step();
        check_out("bp.A", sx(32'hFFFFFFFF), 3'd1, 1'b0, 32'hA);
        check("bp.A.in_ready", 64'(in_ready), 64'd1);
        in_instr  = 32'hFE112E23; in_tag = 32'hB;
        step();
        check("bp.B.in_ready", 64'(in_ready), 64'd0);
        check_out("bp.hold1", sx(32'hFFFFFFFF), 3'd1, 1'b0, 32'hA);
        in_instr  = 32'h123452B7; in_tag = 32'hC;
        step();
        check("bp.C.in_ready", 64'(in_ready), 64'd0);
        check_out("bp.hold2", sx(32'hFFFFFFFF), 3'd1, 1'b0, 32'hA);
        out_ready = 1'b1;
        step();
        check_out("bp.B", sx(32'hFFFFFFFC), 3'd2, 1'b0, 32'hB);
        check("bp.release.in_ready", 64'(in_ready), 64'd1);
        step();
        check_out("bp.C", sx(32'h12345000), 3'd4, 1'b0, 32'hC);
        in_valid = 1'b0;
        step();
        check("bp.empty", 64'(out_valid), 64'd0);
        check("bp.end.in_ready", 64'(in_ready), 64'd1);

        // ---------------- reset mid-stall ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h001000EF; in_tag = 32'hD;
        step();
        in_instr  = 32'hFE000CE3; in_tag = 32'hE;
        step();
        in_valid  = 1'b0;
        check("ms.full.in_ready", 64'(in_ready), 64'd0);
        check("ms.full.out_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ms.rst.out_valid", 64'(out_valid), 64'd0);
        check("ms.rst.in_ready",  64'(in_ready),  64'd0);
        check("ms.rst.out_tag",   64'(out_tag),   64'd0);
        check("ms.rst.out_imm",   64'(out_imm),   64'd0);
        step();
        #2;
        rst = 1'b0;
        #1;
        check("ms.rel.in_ready_before_edge", 64'(in_ready), 64'd0);
        step();
        check("ms.rel.in_ready", 64'(in_ready), 64'd1);
        check("ms.rel.out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h00309093; in_tag = 32'hF;
        step();
        check_out("ms.first", sx(32'h00000003), 3'd6, 1'b0, 32'hF);
        in_valid = 1'b0;
        step();
        check("ms.drained", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, flow-controlled immediate generator for the RISC-V datapath: the parametrised successor to the combinational immediate decoder. It decodes every RV32I/RV64I immediate format (I, S, B, U, J, shift-amount, optional CSR zimm) with correct sign extension to `XLEN`. It classifies the format and flags illegal opcodes. It sits between fetch and execute as a one-stage pipeline slice, with valid/ready handshakes on both sides and a skid buffer so that `in_ready` is a registered signal.

## Interface
- `XLEN`, default 32: datapath width; legal values are 32 or 64.
- `TAG_W`, default 32: width of the sideband tag (typically PC), passed through unchanged.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  block can accept; registered.
- `in_instr`  in  32  instruction word.
- `in_tag`  in  TAG_W  sideband tag.
- `out_valid`  out  1  output register holds a result.
- `out_ready`  in  1  downstream accepts.
- `out_imm`  out  XLEN  extended immediate.
- `out_fmt`  out  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHAMT, 7=CSR.
- `out_illegal`  out  1  opcode not recognised.
- `out_tag`  out  TAG_W  tag of the instruction on the output.

## Operation
Opcode to format mapping (opcode = `instr[6:0]`):
- `0110011` (OP): R; imm is 0.
- `0010011` (OP-IMM):
  - funct3 1 or 5: SHAMT; imm is `instr[24:20]` zero-extended when `XLEN`=32, `instr[25:20]` zero-extended when `XLEN`=64.
  - Otherwise: I.
- `0000011` (LOAD), `1100111` (JALR), `1110011` (SYSTEM): I; imm is `instr[31:20]` sign-extended.
- `0100011` (STORE): S; imm is `{instr[31:25], instr[11:7]}` sign-extended.
- `1100011` (BRANCH): B; imm is `{instr[31], instr[7], instr[30:25], instr[11:8], 0}` sign-extended.
- `0110111` (LUI), `0010111` (AUIPC): U; imm is `{instr[31:12], 12'b0}` sign-extended from bit 31.
- `1101111` (JAL): J; imm is `{instr[31], instr[19:12], instr[20], instr[30:21], 0}` sign-extended.
- Any other opcode: `out_illegal`=1, `out_fmt`=0, `out_imm`=0.
- All sign extension fills to `XLEN` from the stated sign bit. There is no truncation path.

Datapath and buffering:
- Decode is combinational on the accepted word. The result is captured into the output register, or into the skid register.
- The skid buffer holds one entry (decoded imm/fmt/illegal/tag).
- `in_ready` = NOT `skid_valid`, registered.

## Timing
- Latency: 1 cycle from input handshake to `out_valid`. Sustained throughput: 1 per cycle while `out_ready`=1.
- Transfers occur only on cycles where valid and ready are both high.
- Input accepted while the output register is empty, or is being drained this cycle: the result goes to the output register.
- Input accepted while the output register is full and not draining: the result goes to the skid register. `in_ready` falls the next cycle.
- Output drains while the skid register is full: the output register loads from skid, skid empties, and `in_ready` rises the next cycle.
- Simultaneous output drain and input accept with the skid register empty: the output register loads the new word. No bubble.
- `out_*` hold stable while `out_valid`=1 and `out_ready`=0.
- Ordering is strictly FIFO. No instruction is dropped or duplicated.
- Reset (asynchronous, takes effect at any time, including mid-stall):
  - `out_valid`=0, `out_imm`=0, `out_fmt`=0, `out_illegal`=0, `out_tag`=0.
  - Skid register empty; `in_ready`=0.
  - `in_ready` rises at the first clock edge after `rst` deasserts.
  - In-flight entries are discarded.

## Configuration
- `IMM_GEN_ZICSR_EN` defined: SYSTEM with funct3 ∈ {5, 6, 7} gives `out_fmt`=7 and imm = `instr[19:15]` zero-extended (zimm). The CSR address is not output.
- `IMM_GEN_ZICSR_EN` undefined: those encodings decode as I (sign-extended `instr[31:20]`). Format code 7 is never produced.

## Test plan
- `0xFFF00093` (addi -1), then `0xFE112E23` (sw -4), with `out_ready`=1 → next cycles give imm `0xFFFFFFFF` fmt 1, then `0xFFFFFFFC` fmt 2. With `XLEN`=64, all-ones sign extension to 64 bits.
- `0xFE000CE3` (beq -8), `0x123452B7` (lui), `0x001000EF` (jal 2048), `0x00309093` (slli 3) back-to-back → imm `0xFFFFFFF8`/3, `0x12345000`/4, `0x00000800`/5, `0x3`/6, with no bubbles.
- `0x300FD073` (csrrwi) → with `IMM_GEN_ZICSR_EN`: imm `0x1F`, fmt 7. Without it: imm `0x300`, fmt 1.
- Opcode `0x7F` word → `out_illegal`=1, imm 0, fmt 0.
- Backpressure: hold `out_ready`=0 with 3 valid inputs → 2 accepted, `in_ready`=0. Release → outputs arrive in order with tags intact. Then `in_ready`=1.
- Assert `rst` mid-stall with both registers full → `out_valid`=0 and `in_ready`=0 immediately. After release, the first new instruction emerges 1 cycle after acceptance.
